// File: rtl/msg_scroll_ctrl_if.sv
// Message-scroller bus: append port, scroll control and the registered display window.
interface msg_scroll_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          wr_valid;
    logic [5:0]    wr_data;
    logic          wr_ready;
    logic          start;
    logic          loop;
    logic          clear;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [4:0]    hex2;
    logic [4:0]    hex1;
    logic [4:0]    hex0;
    logic [2:0]    dp_out;
    logic [2:0]    en_out;

    modport master (
        output wr_valid, wr_data, start, loop, clear,
        input  wr_ready, busy, done, count, hex2, hex1, hex0, dp_out, en_out
    );

    modport slave (
        input  wr_valid, wr_data, start, loop, clear,
        output wr_ready, busy, done, count, hex2, hex1, hex0, dp_out, en_out
    );
endinterface

// File: rtl/msg_scroll_ctrl.sv
// Scrolls a stored glyph message right-to-left across three seven-segment digits.
module msg_scroll_ctrl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_DIV = 12_500_000
) (
    input logic              clk,
    input logic              reset_n,
    msg_scroll_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Window position reaches count+2, i.e. up to DEPTH+2.
    localparam int unsigned PW = AW + 2;
    localparam int unsigned SW = $clog2(STEP_DIV);

    localparam logic [4:0]    Blank   = 5'b10010;
    localparam logic [SW-1:0] LastPre = SW'(STEP_DIV - 1);

    typedef enum logic [0:0] {StIdle, StScroll} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  p_q, p_d;
    logic [SW-1:0]  presc_q, presc_d;
    logic [5:0]     mem [DEPTH];

    logic [2:0][4:0] hex_q, hex_d;
    logic [2:0]      dp_q, dp_d;
    logic [2:0]      en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic wr_ready;
    logic wr_acc;
    logic tick;
    logic at_end;

    assign wr_ready = (state_q == StIdle) && (count_q < CW'(DEPTH)) && !bus.clear;
    assign wr_acc   = bus.wr_valid && wr_ready;
    assign tick     = (presc_q == LastPre);
    assign at_end   = (p_q == ({1'b0, count_q} + PW'(2)));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, buffer fill level, window position and prescaler.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = StIdle;
            count_d = '0;
            p_d     = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_acc) begin
                        count_d = count_q + CW'(1);
                    end
                    // Gate on the pre-write count; a same-cycle write still joins the scroll.
                    if (bus.start && (count_q != '0)) begin
                        state_d = StScroll;
                        p_d     = '0;
                        presc_d = '0;
                    end
                end
                StScroll: begin
                    presc_d = tick ? '0 : presc_q + SW'(1);
                    if (tick) begin
                        if (!at_end) begin
                            p_d = p_q + PW'(1);
                        end else begin
                            p_d = '0;
                            if (!bus.loop) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Window for the next position so display and position change on the same edge.
    always_comb begin
        logic [PW-1:0] idx;
        logic [5:0]    entry;
        idx    = '0;
        entry  = '0;
        hex_d  = {3{Blank}};
        dp_d   = '0;
        en_d   = '0;
        busy_d = (state_d == StScroll);
        for (int k = 0; k < 3; k++) begin
            idx = p_d - PW'(k);
            if ((state_d == StScroll) && (p_d >= PW'(k)) && (idx < {1'b0, count_d})) begin
                entry    = mem[idx[AW-1:0]];
                hex_d[k] = entry[4:0];
                dp_d[k]  = entry[5];
                en_d[k]  = 1'b1;
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            p_q     <= '0;
            presc_q <= '0;
            hex_q   <= {3{Blank}};
            dp_q    <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            p_q     <= p_d;
            presc_q <= presc_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Message buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[count_q[AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.hex2     = hex_q[2];
    assign bus.hex1     = hex_q[1];
    assign bus.hex0     = hex_q[0];
    assign bus.dp_out   = dp_q;
    assign bus.en_out   = en_q;
endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// Directed bench for msg_scroll_ctrl with DEPTH=16, STEP_DIV=4.
module tb_msg_scroll_ctrl;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned STEP_DIV = 4;
    localparam logic [4:0]  BLANK    = 5'b10010;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    msg_scroll_ctrl_if #(.DEPTH(DEPTH)) bus ();

    msg_scroll_ctrl #(
        .DEPTH   (DEPTH),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        step(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    int done_seen;
    int busy_low;

    initial begin
        reset_n      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.loop     = 1'b0;
        bus.clear    = 1'b0;
        #12;
        // Reset state.
        chk("rst_hex0", 32'(bus.hex0), 32'(BLANK));
        chk("rst_hex2", 32'(bus.hex2), 32'(BLANK));
        chk("rst_en", 32'(bus.en_out), 32'h0);
        chk("rst_dp", 32'(bus.dp_out), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);

        // Basic three-glyph scroll.
        wr(6'h01);
        wr(6'h22);
        wr(6'h03);
        chk("basic_count", 32'(bus.count), 32'd3);
        pulse_start();                             // now at t+1
        chk("basic_busy", 32'(bus.busy), 32'h1);
        chk("basic_t1_hex0", 32'(bus.hex0), 32'h01);
        chk("basic_t1_hex1", 32'(bus.hex1), 32'(BLANK));
        chk("basic_t1_en", 32'(bus.en_out), 32'b001);
        step(8);                                   // t+9, p=2
        chk("basic_p2_hex2", 32'(bus.hex2), 32'h01);
        chk("basic_p2_hex1", 32'(bus.hex1), 32'h02);
        chk("basic_p2_hex0", 32'(bus.hex0), 32'h03);
        chk("basic_p2_en", 32'(bus.en_out), 32'b111);
        chk("basic_p2_dp", 32'(bus.dp_out), 32'b010);
        step(15);                                  // t+24
        chk("basic_t24_done", 32'(bus.done), 32'h0);
        chk("basic_t24_busy", 32'(bus.busy), 32'h1);
        step(1);                                   // t+25
        chk("basic_done", 32'(bus.done), 32'h1);
        chk("basic_done_busy", 32'(bus.busy), 32'h0);
        chk("basic_done_en", 32'(bus.en_out), 32'h0);
        chk("basic_done_hex0", 32'(bus.hex0), 32'(BLANK));
        step(1);
        chk("basic_done_pulse", 32'(bus.done), 32'h0);

        // Fill to DEPTH and overflow.
        pulse_clear();
        chk("clr_count", 32'(bus.count), 32'h0);
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = {i[0], 5'(i)};
            step(1);
        end
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_wr_ready", 32'(bus.wr_ready), 32'h0);
        bus.wr_data = 6'h3f;
        step(1);
        chk("full_drop_count", 32'(bus.count), 32'd16);
        bus.wr_valid = 1'b0;
        pulse_start();
        chk("full_busy", 32'(bus.busy), 32'h1);
        chk("full_hex0", 32'(bus.hex0), 32'h00);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 6'h05;
        chk("scroll_wr_ready", 32'(bus.wr_ready), 32'h0);
        step(1);
        bus.wr_valid = 1'b0;
        chk("scroll_wr_count", 32'(bus.count), 32'd16);

        // Clear mid-scroll with start and write.
        bus.clear    = 1'b1;
        bus.start    = 1'b1;
        bus.wr_valid = 1'b1;
        chk("clear_wr_ready", 32'(bus.wr_ready), 32'h0);
        step(1);
        bus.clear    = 1'b0;
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        chk("clear_busy", 32'(bus.busy), 32'h0);
        chk("clear_count", 32'(bus.count), 32'h0);
        chk("clear_en", 32'(bus.en_out), 32'h0);
        chk("clear_hex0", 32'(bus.hex0), 32'(BLANK));
        chk("clear_done", 32'(bus.done), 32'h0);
        pulse_start();
        chk("empty_start_busy", 32'(bus.busy), 32'h0);
        step(1);
        chk("empty_start_busy2", 32'(bus.busy), 32'h0);
        chk("empty_start_done", 32'(bus.done), 32'h0);

        // Looping two-glyph scroll: period (2+3)*4 = 20 cycles.
        wr(6'h05);
        wr(6'h26);
        bus.loop = 1'b1;
        pulse_start();                             // t+1, p=0
        step(4);                                   // t+5, p=1
        chk("loop_p1_hex0", 32'(bus.hex0), 32'h06);
        chk("loop_p1_hex1", 32'(bus.hex1), 32'h05);
        chk("loop_p1_dp", 32'(bus.dp_out), 32'b001);
        chk("loop_p1_en", 32'(bus.en_out), 32'b011);
        done_seen = 0;
        busy_low  = 0;
        for (int i = 0; i < 56; i++) begin
            step(1);
            if (bus.done === 1'b1) done_seen++;
            if (bus.busy !== 1'b1) busy_low++;
        end                                        // t+61, p=0 again
        chk("loop_no_done", 32'(done_seen), 32'd0);
        chk("loop_busy_held", 32'(busy_low), 32'd0);
        chk("loop_wrap_hex0", 32'(bus.hex0), 32'h05);
        chk("loop_wrap_en", 32'(bus.en_out), 32'b001);
        bus.loop = 1'b0;
        step(19);                                  // t+80, last tick cycle
        chk("unloop_pre_done", 32'(bus.done), 32'h0);
        chk("unloop_pre_busy", 32'(bus.busy), 32'h1);
        step(1);
        chk("unloop_done", 32'(bus.done), 32'h1);
        chk("unloop_busy", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-scroll.
        pulse_start();
        step(8);                                   // p=2
        chk("arst_pre_en", 32'(bus.en_out), 32'b110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_en", 32'(bus.en_out), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_hex1", 32'(bus.hex1), 32'(BLANK));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("arst_idle_busy", 32'(bus.busy), 32'h0);

        // Start and write in the same idle cycle.
        wr(6'h01);
        wr(6'h02);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 6'h07;
        bus.start    = 1'b1;
        step(1);                                   // t+1
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        chk("sw_count", 32'(bus.count), 32'd3);
        chk("sw_busy", 32'(bus.busy), 32'h1);
        step(8);                                   // t+9, p=2
        chk("sw_p2_hex0", 32'(bus.hex0), 32'h07);
        chk("sw_p2_en", 32'(bus.en_out), 32'b111);
        step(15);                                  // t+24
        chk("sw_pre_done", 32'(bus.done), 32'h0);
        step(1);                                   // t+25
        chk("sw_done", 32'(bus.done), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
